// File: rtl/cordic_pkg.sv
// ============================================================================
//  Module      : cordic_pkg
//  Description : Shared constants for the CORDIC rotation pipeline.
//                Angles are two's-complement with 14 fractional bits, so
//                the LSB weighs 2^-14 rad. A full angle is ANGLE_BITS+1
//                bits wide (sign plus ANGLE_BITS magnitude bits).
//  Contents    : ANGLE_BITS, ANGLE_W, ANGLE_FRAC, PI, HALF_PI, TWO_PI
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cordic_pkg;

    // Angle magnitude width; the signed angle is ANGLE_BITS+1 bits wide.
    localparam int ANGLE_BITS = 16;
    localparam int ANGLE_W    = ANGLE_BITS + 1;

    // Number of fractional bits in the angle format (LSB = 2^-14 rad).
    localparam int ANGLE_FRAC = 14;

    // Angles expressed in angle LSBs.
    localparam int PI         = 51472;
    localparam int HALF_PI    = 25736;
    localparam int TWO_PI     = 102944;

endpackage : cordic_pkg

`default_nettype wire

// File: rtl/cordic_phase_gen_if.sv
// ============================================================================
//  Module      : cordic_phase_gen_if
//  Description : Configuration, request and output handshake bundle of the
//                CORDIC phase generator.
//  Signals     : cfg_we, cfg_clr, cfg_freq, cfg_phase  - configuration
//                en                                    - sample request
//                out_ready, out_valid, angle, flip     - output handshake
//  Modports    : master - drives config/requests, consumes output
//                slave  - the phase generator itself
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_phase_gen_if
    import cordic_pkg::*;
#(
    parameter int BITS = ANGLE_BITS
);

    logic                cfg_we;
    logic                cfg_clr;
    logic signed [BITS:0] cfg_freq;
    logic signed [BITS:0] cfg_phase;
    logic                en;
    logic                out_ready;
    logic                out_valid;
    logic signed [BITS:0] angle;
    logic                flip;

    modport master (
        output cfg_we,
        output cfg_clr,
        output cfg_freq,
        output cfg_phase,
        output en,
        output out_ready,
        input  out_valid,
        input  angle,
        input  flip
    );

    modport slave (
        input  cfg_we,
        input  cfg_clr,
        input  cfg_freq,
        input  cfg_phase,
        input  en,
        input  out_ready,
        output out_valid,
        output angle,
        output flip
    );

endinterface : cordic_phase_gen_if

`default_nettype wire

// File: rtl/cordic_quadrant_fold.sv
// ============================================================================
//  Module      : cordic_quadrant_fold
//  Description : Combinational quadrant fold. Maps an angle in [-PI, PI)
//                into the CORDIC convergence range [-HALF_PI, HALF_PI] by
//                shifting it by PI when it lies outside; the shift is
//                reported on flip so sine and cosine can be negated later.
//                Exactly +/-HALF_PI passes through unfolded.
//  Ports       : x      in  BITS+1 signed  angle in [-PI, PI)
//                angle  out BITS+1 signed  folded angle
//                flip   out 1              1 when a PI shift was applied
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_quadrant_fold #(
    parameter int BITS    = cordic_pkg::ANGLE_BITS,
    parameter int PI      = cordic_pkg::PI,
    parameter int HALF_PI = cordic_pkg::HALF_PI
) (
    input  wire logic signed [BITS:0] x,
    output logic signed [BITS:0]      angle,
    output logic                      flip
);

    import cordic_pkg::*;

    localparam logic signed [BITS:0] C_PI       = (BITS+1)'(PI);
    localparam logic signed [BITS:0] C_HALF_PI  = (BITS+1)'(HALF_PI);
    localparam logic signed [BITS:0] C_NHALF_PI = (BITS+1)'(-HALF_PI);

    // With x in [-PI, PI) both shifted results land inside (-PI/2, PI/2),
    // so the BITS+1 bit subtraction/addition cannot overflow.
    always_comb begin
        angle = x;
        flip  = 1'b0;
        if (x > C_HALF_PI) begin
            angle = x - C_PI;
            flip  = 1'b1;
        end else if (x < C_NHALF_PI) begin
            angle = x + C_PI;
            flip  = 1'b1;
        end
    end

endmodule : cordic_quadrant_fold

`default_nettype wire

// File: rtl/cordic_phase_gen.sv
// ============================================================================
//  Module      : cordic_phase_gen
//  Description : Phase source for the CORDIC rotation pipeline. Accumulates
//                a frequency word into a phase wrapped to [-PI, PI), adds a
//                phase offset (also wrapped), then folds the result into
//                [-HALF_PI, HALF_PI] with a flip sideband. Three register
//                stages (accumulator/stage B/stage C) stall together under
//                the valid/ready output handshake.
//  Ports       : clk   in  1   clock, rising edge
//                rst   in  1   synchronous active-high reset
//                bus   slave   cordic_phase_gen_if (config, en, output)
//  Latency     : a request accepted in cycle k is valid in cycle k+2
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_phase_gen #(
    parameter int BITS    = cordic_pkg::ANGLE_BITS,
    parameter int PI      = cordic_pkg::PI,
    parameter int HALF_PI = cordic_pkg::HALF_PI
) (
    input  wire logic            clk,
    input  wire logic            rst,
    cordic_phase_gen_if.slave    bus
);

    import cordic_pkg::*;

    // Extended-width constants for the wrap comparison.
    localparam logic signed [BITS+1:0] C_PI_X     = (BITS+2)'(PI);
    localparam logic signed [BITS+1:0] C_NPI_X    = (BITS+2)'(-PI);
    // Angle-width constants. 2*PI does not fit BITS+1 bits, but the wrapped
    // result always does, so subtracting its truncated pattern modulo
    // 2^(BITS+1) yields the exact wrapped value.
    localparam logic signed [BITS:0]   C_PI_A     = (BITS+1)'(PI);
    localparam logic signed [BITS:0]   C_NPI_A    = (BITS+1)'(-PI);
    localparam logic signed [BITS:0]   C_TWO_PI_A = (BITS+1)'(2 * PI);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic signed [BITS:0] r_freq;
    logic signed [BITS:0] r_off;
    logic signed [BITS:0] r_acc;
    logic signed [BITS:0] r_sum;
    logic                 r_vb;
    logic signed [BITS:0] r_angle;
    logic                 r_flip;
    logic                 r_out_valid;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic                   w_adv;
    logic signed [BITS+1:0] w_acc_sum;
    logic signed [BITS:0]   w_acc_wrap;
    logic signed [BITS+1:0] w_off_sum;
    logic signed [BITS:0]   w_off_wrap;
    logic signed [BITS:0]   w_freq_sat;
    logic signed [BITS:0]   w_phase_sat;
    logic signed [BITS:0]   w_fold_angle;
    logic                   w_fold_flip;

    // The whole pipeline moves only when the output slot is free or drained.
    assign w_adv = !r_out_valid || bus.out_ready;

    // Next accumulator value: acc + freq wrapped into [-PI, PI).
    always_comb begin
        w_acc_sum  = {r_acc[BITS], r_acc} + {r_freq[BITS], r_freq};
        w_acc_wrap = w_acc_sum[BITS:0];
        if (w_acc_sum >= C_PI_X) begin
            w_acc_wrap = w_acc_sum[BITS:0] - C_TWO_PI_A;
        end else if (w_acc_sum < C_NPI_X) begin
            w_acc_wrap = w_acc_sum[BITS:0] + C_TWO_PI_A;
        end
    end

    // Offset phase for stage B: current acc + offset wrapped into [-PI, PI).
    always_comb begin
        w_off_sum  = {r_acc[BITS], r_acc} + {r_off[BITS], r_off};
        w_off_wrap = w_off_sum[BITS:0];
        if (w_off_sum >= C_PI_X) begin
            w_off_wrap = w_off_sum[BITS:0] - C_TWO_PI_A;
        end else if (w_off_sum < C_NPI_X) begin
            w_off_wrap = w_off_sum[BITS:0] + C_TWO_PI_A;
        end
    end

    // Configuration words are clamped to [-PI, PI] so the single-step wrap
    // above is always sufficient.
    always_comb begin
        w_freq_sat = bus.cfg_freq;
        if (bus.cfg_freq > C_PI_A) begin
            w_freq_sat = C_PI_A;
        end else if (bus.cfg_freq < C_NPI_A) begin
            w_freq_sat = C_NPI_A;
        end
    end

    always_comb begin
        w_phase_sat = bus.cfg_phase;
        if (bus.cfg_phase > C_PI_A) begin
            w_phase_sat = C_PI_A;
        end else if (bus.cfg_phase < C_NPI_A) begin
            w_phase_sat = C_NPI_A;
        end
    end

    cordic_quadrant_fold #(
        .BITS    (BITS),
        .PI      (PI),
        .HALF_PI (HALF_PI)
    ) u_fold (
        .x     (r_sum),
        .angle (w_fold_angle),
        .flip  (w_fold_flip)
    );

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_freq      <= '0;
            r_off       <= '0;
            r_acc       <= '0;
            r_sum       <= '0;
            r_vb        <= 1'b0;
            r_angle     <= '0;
            r_flip      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            // Loads ignore the stall; an advance in the same cycle still
            // sees the old values because they are read from the registers.
            if (bus.cfg_we) begin
                r_freq <= w_freq_sat;
                r_off  <= w_phase_sat;
            end

            if (w_adv) begin
                if (bus.en) begin
                    r_acc <= w_acc_wrap;
                    r_sum <= w_off_wrap;
                    r_vb  <= 1'b1;
                end else begin
                    r_vb  <= 1'b0;
                end
                r_angle     <= w_fold_angle;
                r_flip      <= w_fold_flip;
                r_out_valid <= r_vb;
            end

            // Clearing the accumulator overrides a simultaneous advance;
            // samples already in stages B/C are left alone.
            if (bus.cfg_we && bus.cfg_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.angle     = r_angle;
    assign bus.flip      = r_flip;

endmodule : cordic_phase_gen

`default_nettype wire

// File: tb/tb_cordic_phase_gen.sv
// ============================================================================
//  Module      : tb_cordic_phase_gen
//  Description : Self-checking bench for cordic_phase_gen. Directed requests
//                push hand-computed (angle, flip) pairs into a queue; a
//                monitor compares each presented output against the queue
//                head and retires it on transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_phase_gen;

    localparam int BITS = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cordic_phase_gen_if #(.BITS(BITS)) bus ();

    cordic_phase_gen #(
        .BITS    (BITS),
        .PI      (51472),
        .HALF_PI (25736)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int angle;
        bit flip;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic drive(input bit e, input bit rdy, input bit we = 1'b0,
                         input bit clr = 1'b0, input int f = 0, input int p = 0);
        bus.en        = e;
        bus.out_ready = rdy;
        bus.cfg_we    = we;
        bus.cfg_clr   = clr;
        bus.cfg_freq  = (BITS+1)'(f);
        bus.cfg_phase = (BITS+1)'(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_s(input int a, input bit fl);
        q.push_back('{angle: a, flip: fl});
    endtask

    task automatic sample(input int a, input bit fl);
        drive(1'b1, 1'b1);
        expect_s(a, fl);
        tick();
    endtask

    task automatic load(input bit clr, input int f, input int p);
        drive(1'b0, 1'b1, 1'b1, clr, f, p);
        tick();
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b1);
        repeat (n) tick();
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: compare every presented output against the queue head;
    // the head is retired only when the transfer actually happens.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output angle=%0d flip=%0b required=no output",
                         bus.angle, bus.flip);
            end else begin
                if (bus.angle !== (BITS+1)'(q[0].angle) || bus.flip !== q[0].flip) begin
                    errors++;
                    $display("FAIL out_sample angle=%0d flip=%0b required angle=%0d flip=%0b",
                             bus.angle, bus.flip, q[0].angle, q[0].flip);
                end
                if (bus.out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        drive(1'b0, 1'b1);
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", int'(bus.out_valid), 0);
        chk("reset_angle", int'(bus.angle), 0);
        chk("reset_flip", int'(bus.flip), 0);
        tick();

        // Quarter-pi steps, with first-sample latency checks.
        load(1'b1, 12868, 0);
        drive(1'b1, 1'b1); expect_s(0, 1'b0);
        @(negedge clk); chk("latency_k", int'(bus.out_valid), 0); tick();
        drive(1'b1, 1'b1); expect_s(12868, 1'b0);
        @(negedge clk); chk("latency_k1", int'(bus.out_valid), 0); tick();
        drive(1'b1, 1'b1); expect_s(25736, 1'b0);
        @(negedge clk); chk("latency_k2", int'(bus.out_valid), 1); tick();
        sample(-12868, 1'b1);
        sample(0, 1'b1);
        sample(12868, 1'b1);
        sample(-25736, 1'b0);
        sample(-12868, 1'b0);

        // Stall mid-stream: requests are ignored, output held.
        repeat (3) begin
            drive(1'b1, 1'b0);
            tick();
        end
        sample(0, 1'b0);
        sample(12868, 1'b0);
        sample(25736, 1'b0);

        // Bubble pattern 1,0,1: accumulator advances twice.
        sample(-12868, 1'b1);
        drive(1'b0, 1'b1);
        tick();
        sample(0, 1'b1);
        sample(12868, 1'b1);
        idle(4);

        // freq saturates to +PI: phase alternates 0, -PI.
        load(1'b1, 60000, 0);
        sample(0, 1'b0);
        sample(0, 1'b1);
        sample(0, 1'b0);
        sample(0, 1'b1);
        // freq saturates to -PI, offset saturates to +PI (offset sum wraps).
        load(1'b1, -60000, 60000);
        sample(0, 1'b1);
        sample(0, 1'b0);
        sample(0, 1'b1);
        idle(3);

        // Fold boundaries via the offset with zero frequency.
        load(1'b1, 0, 25736);
        sample(25736, 1'b0);
        load(1'b0, 0, 25737);
        sample(-25735, 1'b1);
        load(1'b0, 0, -25736);
        sample(-25736, 1'b0);
        load(1'b0, 0, -25737);
        sample(25735, 1'b1);
        load(1'b0, 0, 30000);
        sample(-21472, 1'b1);
        idle(3);

        // Config load colliding with an advance uses the old frequency.
        load(1'b1, 1000, 0);
        sample(0, 1'b0);
        sample(1000, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5000, 0);
        expect_s(2000, 1'b0);
        tick();
        sample(3000, 1'b0);
        sample(8000, 1'b0);
        // Clear with an advance: this sample uses acc_old, next starts at 0.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1000, 0);
        expect_s(13000, 1'b0);
        tick();
        sample(0, 1'b0);
        sample(1000, 1'b0);
        sample(2000, 1'b0);
        sample(3000, 1'b0);

        // Reset mid-stream with a config write that must be ignored.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 7777, 0);
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b1);
        @(negedge clk);
        chk("midreset_out_valid", int'(bus.out_valid), 0);
        chk("midreset_angle", int'(bus.angle), 0);
        chk("midreset_flip", int'(bus.flip), 0);
        tick();
        sample(0, 1'b0);
        sample(0, 1'b0);

        // Drain with a bounded wait.
        drive(1'b0, 1'b1);
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            tick();
        end
        chk("drain_pending", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_cordic_phase_gen

`default_nettype wire
